fifo_push_arbiter: RTL and testbench
====================================

Name: fifo_push_arbiter

Overview:
- Round-robin arbiter that shares one fifo_v3 write port between N_REQ requesters.
- Each requester presents valid/ready/last packets. The arbiter picks one requester, holds the grant for a whole packet (lock until last), and drives the FIFO push/data inputs.
- The winning requester ID is prepended to each stored word.
- Placed in front of the shared request FIFO in the AXI-to-Wishbone interconnect.

Parameters:
- N_REQ, 4, number of requesters (≥2).
- DATA_WIDTH, 32, payload bits per beat.
- FIFO_AW, 3, width of the FIFO usage input; must equal the FIFO's ADDR_DEPTH.
- HIGH_WM, 6, usage threshold at which new packets are refused (used only with the optional feature).
- ID_W, $clog2(N_REQ), requester-ID width (derived; do not override).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous abort of the current packet lock
- req_valid_i  in  N_REQ  per-requester beat valid
- req_last_i  in  N_REQ  per-requester last-beat-of-packet flag
- req_data_i  in  N_REQ*DATA_WIDTH  per-requester payload; requester k uses bits [k*DATA_WIDTH +: DATA_WIDTH]
- req_ready_o  out  N_REQ  per-requester beat accepted
- fifo_full_i  in  1  FIFO full flag
- fifo_usage_i  in  FIFO_AW  FIFO fill count
- fifo_push_o  out  1  push strobe to the FIFO
- fifo_data_o  out  ID_W+DATA_WIDTH  {grant_id, payload}
- grant_id_o  out  ID_W  currently granted requester
- locked_o  out  1  a packet is in progress

Behaviour:
- State registers:
  - rr_ptr_q (ID_W bits): highest-priority candidate.
  - lock_q: packet in progress.
  - lock_id_q (ID_W bits): owner of the locked packet.
- Reset values: rr_ptr_q=0, lock_q=0, lock_id_q=0.
- With no valid inputs after reset, the outputs are: req_ready_o=0, fifo_push_o=0, grant_id_o=0, locked_o=0.
- Grant selection is combinational, zero latency:
  - If lock_q=1: grant = lock_id_q.
  - Else: grant = first k with req_valid_i[k]=1, scanning rr_ptr_q, rr_ptr_q+1, … modulo N_REQ.
  - No valid requester: grant_id_o holds lock_id_q if locked, otherwise rr_ptr_q.
- Handshake outputs:
  - req_ready_o[k] = (k==grant) & ~fifo_full_i & ~flush_i & (lock_q | valid requester found).
  - fifo_push_o = req_valid_i[grant] & req_ready_o[grant].
  - ready never depends on the requester's own data.
- Beat accepted = fifo_push_o=1.
  - Accepted beat with last=0 while unlocked: lock_q←1, lock_id_q←grant.
  - Accepted beat with last=1: lock_q←0, rr_ptr_q←(grant+1) mod N_REQ, wrapping from N_REQ-1 to 0.
  - A single-beat packet (last=1 while unlocked) never sets the lock.
- Locked requester drops valid mid-packet: the lock holds, fifo_push_o=0, and all other requesters see ready=0.
- fifo_full_i=1: all ready=0, no state change. Arbitration resumes the cycle full deasserts.
- flush_i=1 (priority over everything): all ready=0, fifo_push_o=0, lock_q←0, rr_ptr_q unchanged.
- Reset mid-packet: lock cleared asynchronously. A requester resuming a packet after reset is treated as starting a new packet.
- fifo_usage_i is ignored unless the optional feature is enabled.

Optional Feature:
- Macro: FIFO_ARB_WATERMARK_EN.
- Defined:
  - While unlocked and (fifo_usage_i ≥ HIGH_WM or fifo_full_i), no new packet is granted: all ready=0, state unchanged.
  - A packet already locked continues until the FIFO is full.
  - This leaves headroom so started packets complete contiguously.
- Undefined: fifo_usage_i is unused, and new packets start whenever the FIFO is not full.

Test Plan:
- Round-robin fairness: N_REQ=4, all valid, single-beat packets (last=1), FIFO never full → grant_id sequence 0,1,2,3,0,1; fifo_data_o[ID_W+DATA_WIDTH-1:DATA_WIDTH] matches each.
- Packet lock: req1 sends a 3-beat packet (last on beat 3) while req0/req2 are valid → three consecutive pushes with id=1, then grant moves to 2, then 0.
- Backpressure: fifo_full_i=1 for 4 cycles during a locked packet → fifo_push_o=0 and all ready=0 for those cycles; the packet resumes with the same id and no beat is lost or duplicated.
- Gap inside packet: locked req2 drops valid for 2 cycles while req3 is valid → no push; req3 ready=0; req2's remaining beats follow, then req3 is granted.
- Flush: flush_i pulsed mid-packet of req0 (rr_ptr=0) → locked_o=0 next cycle, no push during flush; the next grant scans from 0.
- Watermark (FIFO_ARB_WATERMARK_EN, HIGH_WM=6): fifo_usage_i=6, unlocked → no ready. Same usage while locked → pushes continue until fifo_full_i=1.

Source files
------------

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter
//   Round-robin arbiter that shares one FIFO write port between N_REQ
//   requesters. Once the first beat of a multi-beat packet is accepted, the
//   grant stays with that requester until its last beat. Each stored word is
//   {grant_id, payload}.
//
//   Optional feature, enabled by defining FIFO_ARB_WATERMARK_EN:
//   new packets are refused once fifo_usage_i >= HIGH_WM. A packet that is
//   already locked keeps going until the FIFO is full. Without the macro,
//   fifo_usage_i is ignored.
//
// Ports
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   flush_i        synchronous abort of the current packet lock
//   req_valid_i    per-requester beat valid
//   req_last_i     per-requester last-beat flag
//   req_data_i     per-requester payload, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   req_ready_o    per-requester beat accepted
//   fifo_full_i    FIFO full flag
//   fifo_usage_i   FIFO fill count
//   fifo_push_o    push strobe to the FIFO
//   fifo_data_o    {grant_id, payload}
//   grant_id_o     currently granted requester
//   locked_o       a packet is in progress

// Per-requester ready: asserted only on the granted lane.
module fifo_push_arbiter_lane #(
  parameter int ID_W = 2,
  parameter int LANE = 0
) (
  input  logic [ID_W-1:0] grant,
  input  logic            allow,
  output logic            ready
);
  assign ready = allow & (grant == ID_W'(LANE));
endmodule

module fifo_push_arbiter #(
  parameter  int N_REQ      = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int FIFO_AW    = 3,
  parameter  int HIGH_WM    = 6,
  localparam int ID_W       = $clog2(N_REQ)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic [N_REQ-1:0]            req_valid_i,
  input  logic [N_REQ-1:0]            req_last_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [N_REQ-1:0]            req_ready_o,
  input  logic                        fifo_full_i,
  input  logic [FIFO_AW-1:0]          fifo_usage_i,
  output logic                        fifo_push_o,
  output logic [ID_W+DATA_WIDTH-1:0]  fifo_data_o,
  output logic [ID_W-1:0]             grant_id_o,
  output logic                        locked_o
);

  typedef struct packed {
    logic [ID_W-1:0]       id;
    logic [DATA_WIDTH-1:0] data;
  } word_t;

  logic [ID_W-1:0] rr_ptr_q, lock_id_q;
  logic            lock_q;

  logic [ID_W-1:0] scan_id, grant;
  logic            found, allow, last_g;
  word_t           word;

  // Round-robin scan starting at rr_ptr_q. Walking the offsets from the far
  // end down lets the closest valid requester overwrite the others.
  always_comb begin
    found   = 1'b0;
    scan_id = rr_ptr_q;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid_i[(int'(rr_ptr_q) + i) % N_REQ]) begin
        found   = 1'b1;
        scan_id = ID_W'((int'(rr_ptr_q) + i) % N_REQ);
      end
    end
  end

  assign grant = lock_q ? lock_id_q : scan_id;

`ifdef FIFO_ARB_WATERMARK_EN
  // Above the watermark only the packet already in flight may proceed.
  assign allow = ~fifo_full_i & ~flush_i &
                 (lock_q | (found & (int'(fifo_usage_i) < HIGH_WM)));
`else
  logic unused_usage;
  assign unused_usage = ^fifo_usage_i;
  assign allow = ~fifo_full_i & ~flush_i & (lock_q | found);
`endif

  for (genvar k = 0; k < N_REQ; k++) begin : g_lane
    fifo_push_arbiter_lane #(.ID_W(ID_W), .LANE(k)) u_lane (
      .grant (grant),
      .allow (allow),
      .ready (req_ready_o[k])
    );
  end

  assign fifo_push_o = req_valid_i[grant] & req_ready_o[grant];
  assign last_g      = req_last_i[grant];
  assign word.id     = grant;
  assign word.data   = req_data_i[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
  assign fifo_data_o = word;
  assign grant_id_o  = grant;
  assign locked_o    = lock_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else if (flush_i) begin
      lock_q <= 1'b0;
    end else if (fifo_push_o) begin
      if (last_g) begin
        lock_q   <= 1'b0;
        rr_ptr_q <= (grant == ID_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
      end else if (!lock_q) begin
        lock_q    <= 1'b1;
        lock_id_q <= grant;
      end
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
module tb_fifo_push_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int IW = 2;

  logic            clk_i = 1'b0, rst_ni = 1'b0, flush_i = 1'b0;
  logic [N-1:0]    req_valid_i = '0, req_last_i = '0;
  logic [N*DW-1:0] req_data_i = '0;
  logic [N-1:0]    req_ready_o;
  logic            fifo_full_i = 1'b0;
  logic [AW-1:0]   fifo_usage_i = '0;
  logic            fifo_push_o;
  logic [IW+DW-1:0] fifo_data_o;
  logic [IW-1:0]   grant_id_o;
  logic            locked_o;

  fifo_push_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .FIFO_AW(AW), .HIGH_WM(6)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_last_i(req_last_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .fifo_full_i(fifo_full_i), .fifo_usage_i(fifo_usage_i),
    .fifo_push_o(fifo_push_o), .fifo_data_o(fifo_data_o), .grant_id_o(grant_id_o),
    .locked_o(locked_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0] v, l;
    logic       full, flush;
    logic       push;
    logic [1:0] id;
    logic       lk;
    logic [3:0] rdy;
  } vec_t;
  vec_t tbl[$];

  task automatic do_reset();
    rst_ni = 1'b0;
    req_valid_i = '0; req_last_i = '0; fifo_full_i = 1'b0; flush_i = 1'b0;
    fifo_usage_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  // Behavioural reference state
  int  m_ptr, m_own;
  bit  m_lock;

  initial begin
    for (int k = 0; k < N; k++) req_data_i[k*DW +: DW] = 32'hD000_0000 + k;
    do_reset();

    //           v        l        full  flush push id  lk   rdy
    tbl.push_back('{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000}); // reset state
    tbl.push_back('{4'b1111, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0001}); // rr 0
    tbl.push_back('{4'b1111, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0010}); // rr 1
    tbl.push_back('{4'b1111, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 4'b0100}); // rr 2
    tbl.push_back('{4'b1111, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 4'b1000}); // rr 3, wrap
    tbl.push_back('{4'b1111, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0001}); // rr 0
    tbl.push_back('{4'b0111, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0010}); // req1 beat1
    tbl.push_back('{4'b0111, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0010}); // req1 beat2
    tbl.push_back('{4'b0111, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0010}); // req1 last
    tbl.push_back('{4'b0101, 4'b0101, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 4'b0100}); // then 2
    tbl.push_back('{4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0001}); // then 0
    tbl.push_back('{4'b0010, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0010}); // req1 start
    for (int i = 0; i < 4; i++)
      tbl.push_back('{4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 4'b0000}); // full x4
    tbl.push_back('{4'b0010, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0010}); // resume last
    tbl.push_back('{4'b0100, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 4'b0100}); // req2 start
    tbl.push_back('{4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0100}); // gap
    tbl.push_back('{4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0100}); // gap
    tbl.push_back('{4'b1100, 4'b0100, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100}); // req2 last
    tbl.push_back('{4'b1000, 4'b1000, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 4'b1000}); // req3
    tbl.push_back('{4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0001}); // req0 start
    tbl.push_back('{4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 4'b0000}); // flush
    tbl.push_back('{4'b0011, 4'b0011, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0001}); // scan from 0
    tbl.push_back('{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 4'b0000}); // idle -> rr_ptr
    tbl.push_back('{4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 4'b0000}); // full, unlocked
    tbl.push_back('{4'b1111, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0010}); // full released

    foreach (tbl[r]) begin
      req_valid_i = tbl[r].v; req_last_i = tbl[r].l;
      fifo_full_i = tbl[r].full; flush_i = tbl[r].flush;
      #2;
      chk($sformatf("row%0d push/id/lk/rdy", r),
          {fifo_push_o, grant_id_o, locked_o, req_ready_o},
          {tbl[r].push, tbl[r].id, tbl[r].lk, tbl[r].rdy});
      if (tbl[r].push)
        chk($sformatf("row%0d data", r), fifo_data_o,
            {tbl[r].id, 32'hD000_0000 + 32'(tbl[r].id)});
      @(posedge clk_i); #1;
    end

    // Asynchronous reset in the middle of a packet
    req_valid_i = 4'b0100; req_last_i = 4'b0000; fifo_full_i = 1'b0; flush_i = 1'b0;
    @(posedge clk_i); #1;
    chk("pre-reset locked", locked_o, 1'b1);
    #1 rst_ni = 1'b0;
    #1 chk("async reset lock", {locked_o, grant_id_o}, {1'b0, 2'd2});
    req_valid_i = '0;
    #1 chk("async reset idle id", grant_id_o, 2'd0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    req_valid_i = 4'b0100; req_last_i = 4'b0100;
    #2 chk("post-reset new pkt", {fifo_push_o, locked_o, grant_id_o}, {1'b1, 1'b0, 2'd2});
    @(posedge clk_i); #1;

    // Randomized run against a behavioural model
    do_reset();
    m_ptr = 0; m_own = 0; m_lock = 0;
    for (int c = 0; c < 3000; c++) begin
      int  g;
      bit  fnd, allow, e_push;
      logic [3:0] e_rdy;
      req_valid_i  = 4'($urandom);
      req_last_i   = 4'($urandom);
      fifo_full_i  = ($urandom_range(0, 9) < 2);
      flush_i      = ($urandom_range(0, 39) == 0);
      fifo_usage_i = 3'($urandom);
      for (int k = 0; k < N; k++) req_data_i[k*DW +: DW] = $urandom;

      fnd = 0; g = m_ptr;
      if (m_lock) g = m_own;
      else
        for (int d = 0; d < N; d++)
          if (!fnd && req_valid_i[(m_ptr + d) % N]) begin fnd = 1; g = (m_ptr + d) % N; end
`ifdef FIFO_ARB_WATERMARK_EN
      allow = !fifo_full_i && !flush_i && (m_lock || (fnd && fifo_usage_i < 6));
`else
      allow = !fifo_full_i && !flush_i && (m_lock || fnd);
`endif
      e_rdy  = allow ? 4'(1 << g) : 4'b0000;
      e_push = allow && req_valid_i[g];
      #2;
      chk($sformatf("rand%0d push/id/lk/rdy", c),
          {fifo_push_o, grant_id_o, locked_o, req_ready_o},
          {e_push, 2'(g), m_lock, e_rdy});
      if (e_push)
        chk($sformatf("rand%0d data", c), fifo_data_o, {2'(g), req_data_i[g*DW +: DW]});

      if (flush_i) m_lock = 0;
      else if (e_push) begin
        if (req_last_i[g]) begin m_lock = 0; m_ptr = (g + 1) % N; end
        else if (!m_lock) begin m_lock = 1; m_own = g; end
      end
      @(posedge clk_i); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
